cmp_stream_tracker: RTL and testbench

//  Parametrised, registered successor to the 16-bit combinational magnitude comparator.

---
 rtl/cmp_pkg.sv | 14 +
 rtl/cmp_mag_cell.sv | 37 +++
 rtl/cmp_stream_tracker.sv | 138 +++++++++++++
 tb/tb_cmp_stream_tracker.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared encodings and helpers for the streamed magnitude comparator.
// The result is packed as {gt,eq,lt}; exactly one bit is set for a valid compare.
package cmp_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  // Counters up to 32 bits wide share this helper; callers pass their own all-ones ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_val);
    return (cnt >= max_val) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/cmp_mag_cell.sv
// Combinational magnitude compare of x against y, returning a one-hot {gt,eq,lt}.
// Signedness is fixed at elaboration.
module cmp_mag_cell
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [2:0]       res
);

  logic is_gt;
  logic is_eq;

  generate
    if (SIGNED_CMP) begin : g_signed
      assign is_gt = $signed(x) > $signed(y);
    end else begin : g_unsigned
      assign is_gt = x > y;
    end
  endgenerate

  assign is_eq = (x == y);

  always_comb begin
    if (is_eq) begin
      res = CMP_EQ;
    end else if (is_gt) begin
      res = CMP_GT;
    end else begin
      res = CMP_LT;
    end
  end

endmodule

// File: rtl/cmp_stream_tracker.sv
// Registered a/b comparator on a valid/ready stream, with running max/min of a
// and saturating per-class result counters.
module cmp_stream_tracker
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit SIGNED_CMP = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [WIDTH-1:0] max_a,
  output logic [WIDTH-1:0] min_a,
  output logic             trk_valid,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic             out_valid_q, out_valid_d;
  logic [2:0]       res_q, res_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic             trk_valid_q, trk_valid_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;

  logic [2:0] ab_res;
  logic [2:0] max_res;
  logic [2:0] min_res;
  logic       accept;
  logic       consume;

  cmp_mag_cell #(.WIDTH(WIDTH), .SIGNED_CMP(SIGNED_CMP)) u_cmp_ab (
    .x(a), .y(b), .res(ab_res)
  );

  cmp_mag_cell #(.WIDTH(WIDTH), .SIGNED_CMP(SIGNED_CMP)) u_cmp_max (
    .x(a), .y(max_q), .res(max_res)
  );

  cmp_mag_cell #(.WIDTH(WIDTH), .SIGNED_CMP(SIGNED_CMP)) u_cmp_min (
    .x(a), .y(min_q), .res(min_res)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  // A new accept overrides the consume, giving back-to-back throughput.
  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    if (accept) begin
      out_valid_d = 1'b1;
      res_d       = ab_res;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    max_d       = max_q;
    min_d       = min_q;
    trk_valid_d = trk_valid_q;
    gt_cnt_d    = gt_cnt_q;
    eq_cnt_d    = eq_cnt_q;
    lt_cnt_d    = lt_cnt_q;
    if (clear) begin
      max_d       = '0;
      min_d       = '0;
      trk_valid_d = 1'b0;
      gt_cnt_d    = '0;
      eq_cnt_d    = '0;
      lt_cnt_d    = '0;
    end else if (accept) begin
      if (!trk_valid_q) begin
        max_d       = a;
        min_d       = a;
        trk_valid_d = 1'b1;
      end else begin
        if (max_res == CMP_GT) max_d = a;
        if (min_res == CMP_LT) min_d = a;
      end
      case (ab_res)
        CMP_GT:  gt_cnt_d = CNT_W'(sat_inc(32'(gt_cnt_q), CNT_MAX));
        CMP_EQ:  eq_cnt_d = CNT_W'(sat_inc(32'(eq_cnt_q), CNT_MAX));
        CMP_LT:  lt_cnt_d = CNT_W'(sat_inc(32'(lt_cnt_q), CNT_MAX));
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      max_q       <= '0;
      min_q       <= '0;
      trk_valid_q <= 1'b0;
      gt_cnt_q    <= '0;
      eq_cnt_q    <= '0;
      lt_cnt_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      max_q       <= max_d;
      min_q       <= min_d;
      trk_valid_q <= trk_valid_d;
      gt_cnt_q    <= gt_cnt_d;
      eq_cnt_q    <= eq_cnt_d;
      lt_cnt_q    <= lt_cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign {gt, eq, lt}   = res_q;
  assign max_a          = max_q;
  assign min_a          = min_q;
  assign trk_valid      = trk_valid_q;
  assign gt_cnt         = gt_cnt_q;
  assign eq_cnt         = eq_cnt_q;
  assign lt_cnt         = lt_cnt_q;

endmodule

// File: tb/tb_cmp_stream_tracker.sv
// Directed bench: an unsigned CNT_W=4 instance and a signed CNT_W=8 instance
// share one stimulus stream; expected values are hand-computed constants.
module tb_cmp_stream_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;

  logic        u_in_ready, u_out_valid, u_gt, u_eq, u_lt, u_trk;
  logic [15:0] u_max, u_min;
  logic [3:0]  u_gtc, u_eqc, u_ltc;

  logic        s_in_ready, s_out_valid, s_gt, s_eq, s_lt, s_trk;
  logic [15:0] s_max, s_min;
  logic [7:0]  s_gtc, s_eqc, s_ltc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cmp_stream_tracker #(.WIDTH(16), .SIGNED_CMP(1'b0), .CNT_W(4)) dut_u (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(u_in_ready),
    .a(a), .b(b), .out_valid(u_out_valid), .out_ready(out_ready),
    .gt(u_gt), .eq(u_eq), .lt(u_lt), .max_a(u_max), .min_a(u_min), .trk_valid(u_trk),
    .gt_cnt(u_gtc), .eq_cnt(u_eqc), .lt_cnt(u_ltc)
  );

  cmp_stream_tracker #(.WIDTH(16), .SIGNED_CMP(1'b1), .CNT_W(8)) dut_s (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .out_valid(s_out_valid), .out_ready(out_ready),
    .gt(s_gt), .eq(s_eq), .lt(s_lt), .max_a(s_max), .min_a(s_min), .trk_valid(s_trk),
    .gt_cnt(s_gtc), .eq_cnt(s_eqc), .lt_cnt(s_ltc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Unsigned instance: handshake, result, trackers and counters in one go.
  task automatic chk_u(input string tag, input logic ov, input logic [2:0] res,
                       input logic [15:0] mx, input logic [15:0] mn, input logic tv,
                       input logic [3:0] gc, input logic [3:0] ec, input logic [3:0] lc);
    chk({tag, ".u_out_valid"}, 32'(u_out_valid), 32'(ov));
    if (ov) chk({tag, ".u_res"}, 32'({u_gt, u_eq, u_lt}), 32'(res));
    chk({tag, ".u_max"}, 32'(u_max), 32'(mx));
    chk({tag, ".u_min"}, 32'(u_min), 32'(mn));
    chk({tag, ".u_trk"}, 32'(u_trk), 32'(tv));
    chk({tag, ".u_cnt"}, {20'd0, u_gtc, u_eqc, u_ltc}, {20'd0, gc, ec, lc});
  endtask

  task automatic chk_s(input string tag, input logic ov, input logic [2:0] res,
                       input logic [15:0] mx, input logic [15:0] mn, input logic tv,
                       input logic [7:0] gc, input logic [7:0] ec, input logic [7:0] lc);
    chk({tag, ".s_out_valid"}, 32'(s_out_valid), 32'(ov));
    if (ov) chk({tag, ".s_res"}, 32'({s_gt, s_eq, s_lt}), 32'(res));
    chk({tag, ".s_max"}, 32'(s_max), 32'(mx));
    chk({tag, ".s_min"}, 32'(s_min), 32'(mn));
    chk({tag, ".s_trk"}, 32'(s_trk), 32'(tv));
    chk({tag, ".s_cnt"}, {8'd0, s_gtc, s_eqc, s_ltc}, {8'd0, gc, ec, lc});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #3;
    chk_u("reset", 1'b0, 3'b000, 16'h0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    chk("reset.res", 32'({u_gt, u_eq, u_lt, s_gt, s_eq, s_lt}), 32'd0);
    chk("reset.in_ready", 32'(u_in_ready), 32'd1);
    tick(); tick();
    rst = 1'b0;

    // Three compares back to back
    in_valid = 1'b1; a = 16'd10; b = 16'd5;
    tick();
    chk_u("t1.gt", 1'b1, 3'b100, 16'd10, 16'd10, 1'b1, 4'd1, 4'd0, 4'd0);
    a = 16'd10; b = 16'd10;
    tick();
    chk_u("t1.eq", 1'b1, 3'b010, 16'd10, 16'd10, 1'b1, 4'd1, 4'd1, 4'd0);
    a = 16'd5; b = 16'd10;
    tick();
    chk_u("t1.lt", 1'b1, 3'b001, 16'd10, 16'd5, 1'b1, 4'd1, 4'd1, 4'd1);
    chk_s("t1.lt", 1'b1, 3'b001, 16'd10, 16'd5, 1'b1, 8'd1, 8'd1, 8'd1);
    in_valid = 1'b0; a = 'x; b = 'x;
    tick();
    chk_u("t1.idle_x", 1'b0, 3'b001, 16'd10, 16'd5, 1'b1, 4'd1, 4'd1, 4'd1);
    tick();
    chk_s("t1.idle_x", 1'b0, 3'b001, 16'd10, 16'd5, 1'b1, 8'd1, 8'd1, 8'd1);

    // Signed vs unsigned on the same pair
    in_valid = 1'b1; a = 16'hFFFF; b = 16'd1;
    tick();
    chk_u("t2", 1'b1, 3'b100, 16'hFFFF, 16'd5, 1'b1, 4'd2, 4'd1, 4'd1);
    chk_s("t2", 1'b1, 3'b001, 16'd10, 16'hFFFF, 1'b1, 8'd1, 8'd1, 8'd2);
    in_valid = 1'b0;
    tick();

    // Backpressure: result frozen while out_ready=0
    out_ready = 1'b0; in_valid = 1'b1; a = 16'd3; b = 16'd7;
    tick();
    a = 16'd8; b = 16'd2;
    for (int i = 0; i < 3; i++) begin
      chk_u($sformatf("t3.hold%0d", i), 1'b1, 3'b001, 16'hFFFF, 16'd3, 1'b1, 4'd2, 4'd1, 4'd2);
      chk($sformatf("t3.in_ready%0d", i), 32'(u_in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("t3.in_ready_release", 32'(u_in_ready), 32'd1);
    tick();
    chk_u("t3.next", 1'b1, 3'b100, 16'hFFFF, 16'd3, 1'b1, 4'd3, 4'd1, 4'd2);
    in_valid = 1'b0;
    tick();
    chk("t3.drain", 32'(u_out_valid), 32'd0);

    // clear in the same cycle as an accept
    clear = 1'b1; in_valid = 1'b1; a = 16'd7; b = 16'd3;
    tick();
    chk_u("t5.clear", 1'b1, 3'b100, 16'd0, 16'd0, 1'b0, 4'd0, 4'd0, 4'd0);
    clear = 1'b0; a = 16'd2; b = 16'd9;
    tick();
    chk_u("t5.first", 1'b1, 3'b001, 16'd2, 16'd2, 1'b1, 4'd0, 4'd0, 4'd1);
    chk_s("t5.first", 1'b1, 3'b001, 16'd2, 16'd2, 1'b1, 8'd0, 8'd0, 8'd1);
    in_valid = 1'b0;
    tick();

    // Saturation of eq_cnt at 15 on the 4-bit instance
    clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b1; a = 16'h44; b = 16'h44;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("t4.eq_cnt%0d", i), 32'(u_eqc), (i > 15) ? 32'd15 : 32'(i));
      chk($sformatf("t4.res%0d", i), 32'({u_gt, u_eq, u_lt}), 32'b010);
    end
    chk_u("t4.end", 1'b1, 3'b010, 16'h44, 16'h44, 1'b1, 4'd0, 4'd15, 4'd0);
    chk_s("t4.end", 1'b1, 3'b010, 16'h44, 16'h44, 1'b1, 8'd0, 8'd20, 8'd0);
    in_valid = 1'b0;
    tick();

    // Reset with a pending result under backpressure
    out_ready = 1'b0; in_valid = 1'b1; a = 16'd1; b = 16'd2;
    tick();
    chk("t6.pending", 32'(u_out_valid), 32'd1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_u("t6.rst", 1'b0, 3'b000, 16'd0, 16'd0, 1'b0, 4'd0, 4'd0, 4'd0);
    chk_s("t6.rst", 1'b0, 3'b000, 16'd0, 16'd0, 1'b0, 8'd0, 8'd0, 8'd0);
    chk("t6.in_ready", 32'(u_in_ready), 32'd1);
    tick();
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; a = 16'd9; b = 16'd9;
    tick();
    chk_u("t6.after", 1'b1, 3'b010, 16'd9, 16'd9, 1'b1, 4'd0, 4'd1, 4'd0);
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
